instr_encoder_loader: RTL and testbench
=======================================

// Module: instr_encoder_loader
// PURPOSE
// - Inverse of the core's immediate decode: packs opcode/register/funct fields and a
//   32-bit immediate into a RISC-V RV32I instruction word, scattering imm bits per type.
// - Range-checks the immediate and streams legal words into instruction memory through
//   a 2-deep output FIFO at an auto-incrementing word address.
// - Sits between the test/boot program source and the instruction memory write port.
// PARAMETERS
// - ADDR_W     8        instruction memory word-address width
// - BASE_ADDR  0        word address loaded on reset
// - FIFO_DEPTH 2        output FIFO entries (power of two, >=2)
// PORTS
// - clk        in   1       single clock, all state updates on rising edge
// - rst        in   1       asynchronous, active-high reset
// - in_valid   in   1       field bundle valid
// - in_ready   out  1       bundle accepted when in_valid && in_ready
// - in_type    in   3       R=0 I=1 S=2 B=3 U=4 J=5 N=7 (6 = illegal)
// - in_opcode  in   7       instr[6:0]
// - in_rd/in_rs1/in_rs2  in  5 each
// - in_funct3  in   3 ; in_funct7  in  7
// - in_imm     in   32      byte-offset immediate (sign-extended value)
// - addr_load  in   1       load write pointer from addr_in (only when idle)
// - addr_in    in   ADDR_W
// - mem_we     out  1       FIFO head valid
// - mem_ready  in   1       memory accepts head when mem_we && mem_ready
// - mem_addr   out  ADDR_W ; mem_wdata  out  32
// - err        out  1       sticky: an illegal bundle was dropped
// - err_addr   out  ADDR_W  write address that the first dropped bundle would have used
// - wrapped    out  1       sticky: write pointer wrapped past 2^ADDR_W-1
// BEHAVIOUR
// - Reset: in_ready=0 during rst, 1 first cycle after; mem_we=0, mem_addr=BASE_ADDR,
//   mem_wdata=0, err=0, err_addr=0, wrapped=0, FIFO and encode stage empty.
// - Pipeline: encode register (stage E) -> FIFO -> memory. Accept at edge N, with FIFO
//   empty: mem_we=1 after edge N+1 (latency 2). Full throughput 1 word/cycle.
// - in_ready = !E_valid || (FIFO not full) || (FIFO pop this cycle).
// - Encoding: R {f7,rs2,rs1,f3,rd,op}; I {imm[11:0],rs1,f3,rd,op};
//   S {imm[11:5],rs2,rs1,f3,imm[4:0],op}; B {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op};
//   U {imm[31:12],rd,op}; J {imm[20],imm[10:1],imm[11],imm[19:12],rd,op};
//   N -> 32'h0000_0013 (addi x0,x0,0), other fields ignored.
// - Legality: I/S imm in [-2048,2047]; B imm even, in [-4096,4094]; J imm even, in
//   [-2^20,2^20-2]; U imm[11:0]==0; R ignores imm; type 6 always illegal.
// - Illegal bundle: accepted (handshake completes), not written, pointer not advanced,
//   err set; err_addr latched only on first error since reset.
// - Address: each word entering FIFO takes current write pointer, pointer += 1 mod
//   2^ADDR_W; transition 2^ADDR_W-1 -> 0 sets wrapped. mem_addr is the head's stored addr.
// - addr_load honoured only when E and FIFO empty and no accept this cycle; else ignored.
// - FIFO push and pop same cycle when full: both occur, count unchanged.
// - mem_we/mem_addr/mem_wdata hold stable while mem_we && !mem_ready.
// - rst mid-stream: all queued words discarded, nothing further written.
// STRUCTURE
// - Shared package/header: instr type codes (R..N), OPC constants, NOP word 32'h00000013.
// - Sub-module: instr_word_fifo (param width/depth, push/pop/full/empty), instantiated
//   with width 32+ADDR_W. Encode + legality check is combinational logic feeding stage E.
// TESTING
// - addi x1,x0,5 (I,op 13,rd1,imm 5), mem_ready=1 -> wdata 0x00500093 @BASE_ADDR, 2 cycles.
// - Back-to-back sw x2,8(x1) / beq x0,x0,-4 / jal x1,2048 / lui x5,0x12345000 ->
//   0x0020A423, 0xFE000EE3, 0x001000EF, 0x123452B7 at consecutive addresses.
// - mem_ready=0 for 5 cycles with 4 bundles offered -> in_ready drops after 3 accepted,
//   head held stable; release -> all 4 written in order, no loss or duplicate.
// - B imm=3 then I imm=4096 -> both dropped, err=1, err_addr=first address, pointer unchanged.
// - addr_load addr_in=8'hFE, write 3 words -> addrs FE, FF, 00, wrapped=1.
// - rst asserted while FIFO holds 2 words -> mem_we=0 immediately, addr=BASE_ADDR, flags clear.

Source files
------------

// File: rtl/instr_encoder_loader_pkg.sv
// Shared definitions for the RV32I instruction encoder/loader: type codes,
// opcode constants and the combinational field-packing/range-check function.
package instr_encoder_loader_pkg;

  typedef enum logic [2:0] {
    TYPE_R = 3'd0,
    TYPE_I = 3'd1,
    TYPE_S = 3'd2,
    TYPE_B = 3'd3,
    TYPE_U = 3'd4,
    TYPE_J = 3'd5,
    TYPE_X = 3'd6,
    TYPE_N = 3'd7
  } instr_type_e;

  localparam logic [6:0]  OPC_OP     = 7'h33;
  localparam logic [6:0]  OPC_OP_IMM = 7'h13;
  localparam logic [6:0]  OPC_STORE  = 7'h23;
  localparam logic [6:0]  OPC_BRANCH = 7'h63;
  localparam logic [6:0]  OPC_LUI    = 7'h37;
  localparam logic [6:0]  OPC_JAL    = 7'h6f;
  localparam logic [31:0] NOP_WORD   = 32'h0000_0013;

  typedef struct packed {
    logic        legal;
    logic [31:0] word;
  } enc_result_t;

  // A signed immediate fits in N bits when everything from bit N-1 upward is a
  // copy of the sign bit.
  function automatic enc_result_t encode(
    input instr_type_e t,
    input logic [6:0]  op,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [31:0] imm
  );
    enc_result_t r;
    r.legal = 1'b1;
    r.word  = '0;
    case (t)
      TYPE_R: r.word = {f7, rs2, rs1, f3, rd, op};
      TYPE_I: begin
        r.word  = {imm[11:0], rs1, f3, rd, op};
        r.legal = (&imm[31:11]) || !(|imm[31:11]);
      end
      TYPE_S: begin
        r.word  = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
        r.legal = (&imm[31:11]) || !(|imm[31:11]);
      end
      TYPE_B: begin
        r.word  = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
        r.legal = !imm[0] && ((&imm[31:12]) || !(|imm[31:12]));
      end
      TYPE_U: begin
        r.word  = {imm[31:12], rd, op};
        r.legal = !(|imm[11:0]);
      end
      TYPE_J: begin
        r.word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        r.legal = !imm[0] && ((&imm[31:20]) || !(|imm[31:20]));
      end
      TYPE_N: r.word = NOP_WORD;
      default: r.legal = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instr_encoder_loader_fifo.sv
// Small synchronous FIFO holding {address, word} entries ahead of the
// instruction memory write port.
module instr_word_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic [PW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CNT_FULL);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is allowed when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rp];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Packs RV32I field bundles into instruction words, drops illegal immediates,
// and streams legal words to instruction memory at an auto-incrementing address.
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int unsigned       FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_type,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr,
  output logic              wrapped
);

  logic              ready_en;
  logic              e_valid;
  logic              e_legal;
  logic [31:0]       e_word;
  logic [ADDR_W-1:0] wptr;
  enc_result_t       enc;
  logic              accept;
  logic              e_move;
  logic              load_ok;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [31+ADDR_W:0] fifo_din;
  logic [31+ADDR_W:0] fifo_dout;

  assign enc = encode(instr_type_e'(in_type), in_opcode, in_rd, in_rs1, in_rs2,
                      in_funct3, in_funct7, in_imm);

  assign mem_we    = !fifo_empty;
  assign fifo_pop  = mem_we && mem_ready;
  assign in_ready  = ready_en && (!e_valid || !fifo_full || fifo_pop);
  assign accept    = in_valid && in_ready;
  // Illegal words leave stage E through the same slot as legal ones but are
  // never pushed, so the drop point sees the pointer a legal word would take.
  assign e_move    = e_valid && (!fifo_full || fifo_pop);
  assign fifo_push = e_move && e_legal;
  assign fifo_din  = {wptr, e_word};
  assign load_ok   = addr_load && !e_valid && fifo_empty && !accept;

  // An empty FIFO shows the next write address and a zero word.
  assign mem_addr  = fifo_empty ? wptr : fifo_dout[31+ADDR_W:32];
  assign mem_wdata = fifo_empty ? '0   : fifo_dout[31:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_en <= 1'b0;
      e_valid  <= 1'b0;
      e_legal  <= 1'b0;
      e_word   <= '0;
      wptr     <= BASE_ADDR;
      err      <= 1'b0;
      err_addr <= '0;
      wrapped  <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (accept) begin
        e_valid <= 1'b1;
        e_legal <= enc.legal;
        e_word  <= enc.word;
      end else if (e_move) begin
        e_valid <= 1'b0;
      end
      if (fifo_push) begin
        wptr <= wptr + 1'b1;
        if (&wptr) wrapped <= 1'b1;
      end else if (load_ok) begin
        wptr <= addr_in;
      end
      if (e_move && !e_legal) begin
        err <= 1'b1;
        if (!err) err_addr <= wptr;
      end
    end
  end

  instr_word_fifo #(
    .WIDTH (32 + ADDR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: encoding/legality table plus
// stall, error, wrap and mid-stream reset sequences.
`timescale 1ns/1ps
module tb_instr_encoder_loader;
  import instr_encoder_loader_pkg::*;

  localparam int unsigned ADDR_W = 8;
  localparam logic [7:0]  BASE   = 8'h00;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_type;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        addr_load;
  logic [7:0]  addr_in;
  logic        mem_we;
  logic        mem_ready;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        err;
  logic [7:0]  err_addr;
  logic        wrapped;

  always #5 clk = ~clk;

  instr_encoder_loader #(
    .ADDR_W     (ADDR_W),
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_type   (in_type),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .addr_load (addr_load),
    .addr_in   (addr_in),
    .mem_we    (mem_we),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .err       (err),
    .err_addr  (err_addr),
    .wrapped   (wrapped)
  );

  typedef struct {
    logic [2:0]  t;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        legal;
    logic [31:0] word;
  } vec_t;

  vec_t        vecs[$];
  int          nchk = 0;
  int          nerr = 0;
  logic [39:0] got_q[$];
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (!rst && mem_we && mem_ready) got_q.push_back({mem_addr, mem_wdata});

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1);
  end

  function automatic vec_t mk(logic [2:0] t, logic [6:0] op, logic [4:0] rd, logic [4:0] rs1,
                              logic [4:0] rs2, logic [2:0] f3, logic [6:0] f7, logic [31:0] imm,
                              logic legal, logic [31:0] word);
    vec_t v;
    v.t = t; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.f3 = f3; v.f7 = f7; v.imm = imm; v.legal = legal; v.word = word;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_type = v.t; in_opcode = v.op; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2;
    in_funct3 = v.f3; in_funct7 = v.f7; in_imm = v.imm; in_valid = 1'b1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input vec_t v);
    int unsigned n = 0;
    drive(v);
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      nchk++;
      nerr++;
      $display("FAIL send_timeout: in_ready 0 expected 1");
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_writes(input int unsigned n, input string name);
    int unsigned c = 0;
    while (got_q.size() < n && c < 60) begin
      @(posedge clk);
      c++;
    end
    repeat (4) @(posedge clk);
    #1 check(name, 64'(got_q.size()), 64'(n));
  endtask

  logic [7:0]  exp_ptr;
  logic [7:0]  exp_err_addr;
  logic        first_err;
  int unsigned c0;
  vec_t        nop;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_type = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0;
    in_rs2 = '0; in_funct3 = '0; in_funct7 = '0; in_imm = '0;
    addr_load = 1'b0; addr_in = '0; mem_ready = 1'b1;

    vecs.push_back(mk(TYPE_I, OPC_OP_IMM, 1, 0, 0, 0, 0, 32'h0000_0005, 1, 32'h0050_0093));
    vecs.push_back(mk(TYPE_S, OPC_STORE,  0, 1, 2, 2, 0, 32'h0000_0008, 1, 32'h0020_A423));
    vecs.push_back(mk(TYPE_B, OPC_BRANCH, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 1, 32'hFE00_0EE3));
    vecs.push_back(mk(TYPE_J, OPC_JAL,    1, 0, 0, 0, 0, 32'h0000_0800, 1, 32'h0010_00EF));
    vecs.push_back(mk(TYPE_U, OPC_LUI,    5, 0, 0, 0, 0, 32'h1234_5000, 1, 32'h1234_52B7));
    vecs.push_back(mk(TYPE_R, OPC_OP,     3, 1, 2, 0, 7'h00, 32'hDEAD_BEEF, 1, 32'h0020_81B3));
    vecs.push_back(mk(TYPE_R, OPC_OP,     3, 1, 2, 0, 7'h20, 32'h0000_0000, 1, 32'h4020_81B3));
    vecs.push_back(mk(TYPE_N, 7'h7F,     31, 31, 31, 7, 7'h7F, 32'hFFFF_FFFF, 1, 32'h0000_0013));
    vecs.push_back(mk(TYPE_I, OPC_OP_IMM, 0, 0, 0, 0, 0, 32'hFFFF_F800, 1, 32'h8000_0013));
    vecs.push_back(mk(TYPE_I, OPC_OP_IMM, 1, 0, 0, 0, 0, 32'h0000_07FF, 1, 32'h7FF0_0093));
    vecs.push_back(mk(TYPE_B, OPC_BRANCH, 0, 0, 0, 0, 0, 32'hFFFF_F000, 1, 32'h8000_0063));
    vecs.push_back(mk(TYPE_B, OPC_BRANCH, 0, 0, 0, 0, 0, 32'h0000_0FFE, 1, 32'h7E00_0FE3));
    vecs.push_back(mk(TYPE_J, OPC_JAL,    0, 0, 0, 0, 0, 32'hFFF0_0000, 1, 32'h8000_006F));
    vecs.push_back(mk(TYPE_J, OPC_JAL,    0, 0, 0, 0, 0, 32'h000F_FFFE, 1, 32'h7FFF_F06F));
    vecs.push_back(mk(TYPE_B, OPC_BRANCH, 0, 0, 0, 0, 0, 32'h0000_0003, 0, 32'h0));
    vecs.push_back(mk(TYPE_I, OPC_OP_IMM, 1, 0, 0, 0, 0, 32'h0000_1000, 0, 32'h0));
    vecs.push_back(mk(TYPE_I, OPC_OP_IMM, 1, 0, 0, 0, 0, 32'h0000_0800, 0, 32'h0));
    vecs.push_back(mk(TYPE_S, OPC_STORE,  0, 1, 2, 2, 0, 32'hFFFF_F7FF, 0, 32'h0));
    vecs.push_back(mk(TYPE_J, OPC_JAL,    1, 0, 0, 0, 0, 32'h0010_0000, 0, 32'h0));
    vecs.push_back(mk(TYPE_U, OPC_LUI,    5, 0, 0, 0, 0, 32'h1234_5001, 0, 32'h0));
    vecs.push_back(mk(3'd6,   OPC_OP,     1, 1, 1, 0, 0, 32'h0000_0000, 0, 32'h0));
    nop = mk(TYPE_N, 7'h00, 0, 0, 0, 0, 0, 32'h0, 1, NOP_WORD);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_mem_we", 64'(mem_we), 64'(0));
    check("rst_mem_addr", 64'(mem_addr), 64'(BASE));
    check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_err_addr", 64'(err_addr), 64'(0));
    check("rst_wrapped", 64'(wrapped), 64'(0));
    rst = 1'b0;
    #1 check("in_ready_before_edge", 64'(in_ready), 64'(0));
    @(posedge clk);
    #1 check("in_ready_after_rst", 64'(in_ready), 64'(1));

    // Table: each vector alone with mem_ready=1
    exp_ptr = BASE;
    first_err = 1'b1;
    exp_err_addr = '0;
    foreach (vecs[i]) begin
      send(vecs[i]);
      if (vecs[i].legal) begin
        @(negedge clk);
        check($sformatf("v%0d_we_lat1", i), 64'(mem_we), 64'(0));
        @(negedge clk);
        check($sformatf("v%0d_we_lat2", i), 64'(mem_we), 64'(1));
        check($sformatf("v%0d_wdata", i), 64'(mem_wdata), 64'(vecs[i].word));
        check($sformatf("v%0d_addr", i), 64'(mem_addr), 64'(exp_ptr));
        if (first_err) check($sformatf("v%0d_no_err", i), 64'(err), 64'(0));
        exp_ptr = exp_ptr + 8'd1;
      end else begin
        if (first_err) begin
          exp_err_addr = exp_ptr;
          first_err = 1'b0;
        end
        repeat (3) begin
          @(negedge clk);
          check($sformatf("v%0d_dropped_we", i), 64'(mem_we), 64'(0));
        end
        check($sformatf("v%0d_err", i), 64'(err), 64'(1));
        check($sformatf("v%0d_err_addr", i), 64'(err_addr), 64'(exp_err_addr));
      end
      @(posedge clk);
      #1;
    end

    // Dropped bundles must not have advanced the pointer
    got_q.delete();
    send(nop);
    wait_writes(1, "ptr_after_err_count");
    if (got_q.size() > 0) check("ptr_after_err", 64'(got_q[0]), 64'({exp_ptr, NOP_WORD}));
    exp_ptr = exp_ptr + 8'd1;

    // Back-to-back sw/beq/jal/lui at full throughput
    got_q.delete();
    c0 = cyc;
    for (int k = 1; k <= 4; k++) send(vecs[k]);
    check("b2b_accept_cycles", 64'(cyc - c0), 64'(4));
    wait_writes(4, "b2b_count");
    for (int k = 0; k < 4; k++)
      if (got_q.size() > k)
        check($sformatf("b2b_word%0d", k), 64'(got_q[k]),
              64'({exp_ptr + 8'(k), vecs[k+1].word}));
    exp_ptr = exp_ptr + 8'd4;

    // Backpressure: three bundles fill E + FIFO, the fourth waits
    mem_ready = 1'b0;
    got_q.delete();
    for (int k = 5; k <= 7; k++) send(vecs[k]);
    drive(vecs[8]);
    repeat (2) begin
      @(negedge clk);
      check("stall_in_ready", 64'(in_ready), 64'(0));
      check("stall_we", 64'(mem_we), 64'(1));
      check("stall_addr", 64'(mem_addr), 64'(exp_ptr));
      check("stall_wdata", 64'(mem_wdata), 64'(vecs[5].word));
    end
    @(posedge clk);
    #1 mem_ready = 1'b1;
    send(vecs[8]);
    wait_writes(4, "stall_count");
    for (int k = 0; k < 4; k++)
      if (got_q.size() > k)
        check($sformatf("stall_word%0d", k), 64'(got_q[k]),
              64'({exp_ptr + 8'(k), vecs[k+5].word}));
    exp_ptr = exp_ptr + 8'd4;

    // Pointer load and wrap
    addr_load = 1'b1;
    addr_in = 8'hFE;
    @(posedge clk);
    #1 addr_load = 1'b0;
    @(negedge clk);
    check("load_mem_addr", 64'(mem_addr), 64'(8'hFE));
    check("wrapped_before", 64'(wrapped), 64'(0));
    @(posedge clk);
    #1 got_q.delete();
    for (int k = 0; k < 3; k++) send(nop);
    wait_writes(3, "wrap_count");
    if (got_q.size() == 3) begin
      check("wrap_addr0", 64'(got_q[0][39:32]), 64'(8'hFE));
      check("wrap_addr1", 64'(got_q[1][39:32]), 64'(8'hFF));
      check("wrap_addr2", 64'(got_q[2][39:32]), 64'(8'h00));
    end
    check("wrapped_after", 64'(wrapped), 64'(1));

    // Reset while words are queued
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) send(vecs[k]);
    @(negedge clk);
    check("pre_rst_we", 64'(mem_we), 64'(1));
    #2 rst = 1'b1;
    #1;
    check("midrst_we", 64'(mem_we), 64'(0));
    check("midrst_addr", 64'(mem_addr), 64'(BASE));
    check("midrst_err", 64'(err), 64'(0));
    check("midrst_err_addr", 64'(err_addr), 64'(0));
    check("midrst_wrapped", 64'(wrapped), 64'(0));
    check("midrst_in_ready", 64'(in_ready), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mem_ready = 1'b1;
    got_q.delete();
    repeat (6) @(posedge clk);
    #1;
    check("post_rst_no_writes", 64'(got_q.size()), 64'(0));
    check("post_rst_we", 64'(mem_we), 64'(0));
    check("post_rst_in_ready", 64'(in_ready), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule
